// File: rtl/br_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b control types: sequencer state encoding, opcode / nzp typedefs,
// the BR opcode value, PC-mux select constants and a branch-mask helper.
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef enum logic [2:0] {
        FETCH1   = 3'd0,
        FETCH2   = 3'd1,
        FETCH3   = 3'd2,
        DECODE   = 3'd3,
        BR_TAKEN = 3'd4,
        EXEC     = 3'd5
    } ctrl_state_t;

    typedef logic [3:0] lc3b_opcode;
    typedef logic [2:0] lc3b_nzp;

    localparam lc3b_opcode op_br = 4'b0000;

    localparam logic pcmux_plus2 = 1'b0;
    localparam logic pcmux_br    = 1'b1;

    // A branch condition holds when any flag selected by the mask is set.
    // A zero mask or an uninitialised (all-zero) condition code never matches.
    function automatic logic nzp_match(input lc3b_nzp mask, input lc3b_nzp cc);
        return |(mask & cc);
    endfunction

endpackage

// File: rtl/br_seq_ctrl_cond_eval.sv
// -----------------------------------------------------------------------------
// br_cond_eval
// Combinational branch-condition evaluator.
//   opcode   : IR[15:12]
//   ir_nzp   : IR[11:9] branch mask
//   cc_nzp   : condition-code register {n,z,p}
//   is_br    : opcode is a BR instruction
//   br_taken : BR instruction whose mask matches the condition codes
// -----------------------------------------------------------------------------
module br_cond_eval
    import lc3b_types::*;
#(
    parameter lc3b_opcode OP_BR = op_br
) (
    input  lc3b_opcode opcode,
    input  lc3b_nzp    ir_nzp,
    input  lc3b_nzp    cc_nzp,
    output logic       is_br,
    output logic       br_taken
);

    assign is_br    = (opcode == OP_BR);
    assign br_taken = is_br & nzp_match(ir_nzp, cc_nzp);

endmodule

// File: rtl/br_seq_ctrl.sv
// -----------------------------------------------------------------------------
// br_seq_ctrl
// LC-3b multicycle sequencer: instruction fetch, decode and conditional-branch
// resolution. Non-BR opcodes are handed to the execute controller through an
// exec_req / exec_done handshake. Taken branches are counted (saturating).
//   clk, reset_n          : clock (rising edge), async active-low reset
//   opcode, ir_nzp        : IR[15:12], IR[11:9]
//   cc_nzp                : condition codes {n,z,p}
//   mem_resp, exec_done   : single-cycle completion pulses
//   mem_read, load_mar, load_mdr, load_ir, load_pc, pcmux_sel, exec_req
//                         : datapath / handshake controls
//   br_taken_cnt          : saturating taken-branch counter
// -----------------------------------------------------------------------------
module br_seq_ctrl
    import lc3b_types::*;
#(
    parameter int         CNT_W = 16,
    parameter lc3b_opcode OP_BR = op_br
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       opcode,
    input  logic [2:0]       ir_nzp,
    input  logic [2:0]       cc_nzp,
    input  logic             mem_resp,
    input  logic             exec_done,
    output logic             mem_read,
    output logic             load_mar,
    output logic             load_mdr,
    output logic             load_ir,
    output logic             load_pc,
    output logic             pcmux_sel,
    output logic             exec_req,
    output logic [CNT_W-1:0] br_taken_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_t      state_r;
    ctrl_state_t      next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             is_br_s;
    logic             br_taken_s;

    br_cond_eval #(
        .OP_BR (OP_BR)
    ) u_cond (
        .opcode   (opcode),
        .ir_nzp   (ir_nzp),
        .cc_nzp   (cc_nzp),
        .is_br    (is_br_s),
        .br_taken (br_taken_s)
    );

    // State register; reset returns to the start of a fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH1;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Taken-branch counter: bumps on the edge leaving BR_TAKEN, sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == BR_TAKEN) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state logic. mem_resp and exec_done only matter in their own states.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FETCH1: begin
                next_state_s = FETCH2;
            end
            FETCH2: begin
                if (mem_resp) begin
                    next_state_s = FETCH3;
                end else begin
                    next_state_s = FETCH2;
                end
            end
            FETCH3: begin
                next_state_s = DECODE;
            end
            DECODE: begin
                if (br_taken_s) begin
                    next_state_s = BR_TAKEN;
                end else if (is_br_s) begin
                    next_state_s = FETCH1;
                end else begin
                    next_state_s = EXEC;
                end
            end
            BR_TAKEN: begin
                next_state_s = FETCH1;
            end
            EXEC: begin
                if (exec_done) begin
                    next_state_s = FETCH1;
                end else begin
                    next_state_s = EXEC;
                end
            end
            default: begin
                next_state_s = FETCH1;
            end
        endcase
    end

    // Output decode. Gated directly by reset_n so nothing is driven high while
    // reset is held, even though the state register already reads FETCH1.
    // load_mdr is the one Mealy output: it follows mem_resp inside FETCH2.
    always_comb begin
        mem_read  = 1'b0;
        load_mar  = 1'b0;
        load_mdr  = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        pcmux_sel = pcmux_plus2;
        exec_req  = 1'b0;
        if (!reset_n) begin
            mem_read  = 1'b0;
        end else begin
            case (state_r)
                FETCH1: begin
                    load_mar  = 1'b1;
                    load_pc   = 1'b1;
                    pcmux_sel = pcmux_plus2;
                end
                FETCH2: begin
                    mem_read = 1'b1;
                    load_mdr = mem_resp;
                end
                FETCH3: begin
                    load_ir = 1'b1;
                end
                DECODE: begin
                    load_ir = 1'b0;
                end
                BR_TAKEN: begin
                    // PC already holds PC+2, so the branch adder sees the
                    // incremented PC.
                    load_pc   = 1'b1;
                    pcmux_sel = pcmux_br;
                end
                EXEC: begin
                    exec_req = 1'b1;
                end
                default: begin
                    exec_req = 1'b0;
                end
            endcase
        end
    end

    assign br_taken_cnt = cnt_r;

endmodule

// File: tb/tb_br_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_br_seq_ctrl
// Table-driven bench for br_seq_ctrl (CNT_W=4 so saturation is reachable).
// Each table row holds one cycle's inputs and the outputs expected in that
// cycle; multi-cycle reset corner cases are written out by hand afterwards.
// Output vector bit order: {mem_read, load_mar, load_mdr, load_ir, load_pc,
// pcmux_sel, exec_req}.
// -----------------------------------------------------------------------------
module tb_br_seq_ctrl;

    localparam int CW = 4;

    localparam logic [6:0] O_ZERO = 7'b0000000;
    localparam logic [6:0] O_F1   = 7'b0100100;
    localparam logic [6:0] O_F2   = 7'b1000000;
    localparam logic [6:0] O_F2R  = 7'b1010000;
    localparam logic [6:0] O_F3   = 7'b0001000;
    localparam logic [6:0] O_DEC  = 7'b0000000;
    localparam logic [6:0] O_BRT  = 7'b0000110;
    localparam logic [6:0] O_EX   = 7'b0000001;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [3:0]    opcode = 4'd0;
    logic [2:0]    ir_nzp = 3'd0;
    logic [2:0]    cc_nzp = 3'd0;
    logic          mem_resp = 1'b0;
    logic          exec_done = 1'b0;
    logic          mem_read, load_mar, load_mdr, load_ir, load_pc, pcmux_sel, exec_req;
    logic [CW-1:0] br_taken_cnt;
    logic [6:0]    out_v;

    typedef struct {
        logic [3:0]    op;
        logic [2:0]    ir;
        logic [2:0]    cc;
        logic          resp;
        logic          done;
        logic [6:0]    exp_out;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t          vecs[$];
    logic [CW-1:0] cnt_m;
    int            checks = 0;
    int            failures = 0;

    br_seq_ctrl #(
        .CNT_W (CW),
        .OP_BR (4'b0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .ir_nzp       (ir_nzp),
        .cc_nzp       (cc_nzp),
        .mem_resp     (mem_resp),
        .exec_done    (exec_done),
        .mem_read     (mem_read),
        .load_mar     (load_mar),
        .load_mdr     (load_mdr),
        .load_ir      (load_ir),
        .load_pc      (load_pc),
        .pcmux_sel    (pcmux_sel),
        .exec_req     (exec_req),
        .br_taken_cnt (br_taken_cnt)
    );

    always #5 clk = ~clk;

    assign out_v = {mem_read, load_mar, load_mdr, load_ir, load_pc, pcmux_sel, exec_req};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [2:0] ir, input logic [2:0] cc,
                       input logic resp, input logic done, input logic [6:0] eo);
        vec_t v;
        v.op = op; v.ir = ir; v.cc = cc; v.resp = resp; v.done = done;
        v.exp_out = eo; v.exp_cnt = cnt_m;
        vecs.push_back(v);
    endtask

    // One instruction from FETCH1 to its last cycle. kind: 0 BR not taken,
    // 1 BR taken, 2 handed to execute. stray injects ignored pulses.
    task automatic add_instr(input logic [3:0] op, input logic [2:0] ir, input logic [2:0] cc,
                             input int waits, input int kind, input int ex_cycles,
                             input logic stray);
        add(op, ir, cc, 1'b0, 1'b0, O_F1);
        for (int w = 0; w < waits; w++) begin
            add(op, ir, cc, 1'b0, (stray && (w == 0)), O_F2);
        end
        add(op, ir, cc, 1'b1, 1'b0, O_F2R);
        add(op, ir, cc, stray, 1'b0, O_F3);
        add(op, ir, cc, stray, stray, O_DEC);
        if (kind == 1) begin
            add(op, ir, cc, 1'b0, 1'b0, O_BRT);
            if (cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
        end
        if (kind == 2) begin
            for (int e = 1; e < ex_cycles; e++) begin
                add(op, ir, cc, stray, 1'b0, O_EX);
            end
            add(op, ir, cc, 1'b0, 1'b1, O_EX);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] cc_list [4];
        cc_list[0] = 3'b000; cc_list[1] = 3'b001; cc_list[2] = 3'b010; cc_list[3] = 3'b100;

        // ---- build the vector table ----
        cnt_m = 4'd0;
        add_instr(4'b0001, 3'b000, 3'b000, 2, 2, 3, 1'b1);   // exec, resp on 3rd FETCH2
        add_instr(4'b0000, 3'b010, 3'b010, 0, 1, 0, 1'b0);   // taken, zero-wait
        add_instr(4'b0000, 3'b100, 3'b001, 0, 0, 0, 1'b0);   // not taken
        for (int k = 0; k < 4; k++) begin
            add_instr(4'b0000, 3'b000, cc_list[k], 0, 0, 0, 1'b0);  // NOP mask
        end
        for (int k = 1; k < 4; k++) begin
            add_instr(4'b0000, 3'b111, cc_list[k], 1, 1, 0, 1'b1);  // always taken
        end
        add_instr(4'b0000, 3'b111, 3'b000, 0, 0, 0, 1'b0);   // uninitialised cc
        add_instr(4'b0000, 3'b011, 3'b100, 0, 0, 0, 1'b0);
        add_instr(4'b0000, 3'b011, 3'b010, 0, 1, 0, 1'b0);
        add_instr(4'b1111, 3'b111, 3'b111, 0, 2, 1, 1'b0);   // exec_done on first EXEC cycle
        for (int k = 0; k < 17; k++) begin
            add_instr(4'b0000, 3'b001, 3'b001, 0, 1, 0, 1'b0);
        end
        add_instr(4'b0000, 3'b100, 3'b010, 0, 0, 0, 1'b0);   // saturated count holds

        // ---- reset ----
        #1 reset_n = 1'b0;
        tick();
        chk("reset_out", {9'd0, out_v}, {9'd0, O_ZERO});
        chk("reset_cnt", {12'd0, br_taken_cnt}, 16'd0);
        tick();
        reset_n = 1'b1;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            opcode    = vecs[i].op;
            ir_nzp    = vecs[i].ir;
            cc_nzp    = vecs[i].cc;
            mem_resp  = vecs[i].resp;
            exec_done = vecs[i].done;
            #1;
            chk($sformatf("row%0d_out", i), {9'd0, out_v}, {9'd0, vecs[i].exp_out});
            chk($sformatf("row%0d_cnt", i), {12'd0, br_taken_cnt}, {12'd0, vecs[i].exp_cnt});
            tick();
        end

        // ---- reset mid-FETCH2 ----
        opcode = 4'b0001; mem_resp = 1'b0; exec_done = 1'b0;
        #1 chk("pre_f1", {9'd0, out_v}, {9'd0, O_F1});
        tick();
        chk("mid_f2", {9'd0, out_v}, {9'd0, O_F2});
        #2 reset_n = 1'b0;
        #1 chk("rst_f2_out", {9'd0, out_v}, {9'd0, O_ZERO});
        chk("rst_f2_cnt", {12'd0, br_taken_cnt}, 16'd0);
        tick();
        chk("rst_hold_out", {9'd0, out_v}, {9'd0, O_ZERO});
        reset_n = 1'b1;
        #1 chk("rel1_f1", {9'd0, out_v}, {9'd0, O_F1});

        // ---- reset mid-EXEC ----
        tick();
        mem_resp = 1'b1;
        #1 chk("f2_resp", {9'd0, out_v}, {9'd0, O_F2R});
        tick();
        mem_resp = 1'b0;
        tick();
        tick();
        #1 chk("mid_exec", {9'd0, out_v}, {9'd0, O_EX});
        #1 reset_n = 1'b0;
        #1 chk("rst_ex_out", {9'd0, out_v}, {9'd0, O_ZERO});
        chk("rst_ex_cnt", {12'd0, br_taken_cnt}, 16'd0);
        tick();
        reset_n = 1'b1;
        #1 chk("rel2_f1", {9'd0, out_v}, {9'd0, O_F1});
        tick();
        chk("rel2_f2", {9'd0, out_v}, {9'd0, O_F2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
